// File: rtl/datapath_regfile_alu_pkg.sv
// Shared types and constants for the register-file/ALU datapath.
// Opcodes, register select codes and the status flag bundle.
package datapath_regfile_alu_pkg;

  localparam int DEF_DATAWIDTH     = 8;
  localparam int DEF_SELECTIONALU  = 3;
  localparam int DEF_SELECTIONDECO = 3;

  typedef enum logic [2:0] {
    ALU_PASSA = 3'b000,
    ALU_PASSB = 3'b001,
    ALU_ADD   = 3'b010,
    ALU_SUB   = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_XOR   = 3'b110,
    ALU_NOTA  = 3'b111
  } alu_op_e;

  localparam logic [2:0] SEL_NONE = 3'b111;
  localparam logic [2:0] REG_RP0  = 3'b110;
  localparam logic [2:0] REG_RP1  = 3'b111;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;

endpackage

// File: rtl/datapath_regfile_alu_alu.sv
// Combinational ALU: opcode, A, B -> result, carry, signed overflow.
// SUB carry means "no borrow" (A >= B unsigned).
module alu_unit
  import datapath_regfile_alu_pkg::*;
#(
  parameter int W   = DEF_DATAWIDTH,
  parameter int OPW = DEF_SELECTIONALU
) (
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   res,
  output logic           carry,
  output logic           ovf
);

  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (op)
      ALU_PASSA: res = a;
      ALU_PASSB: res = b;
      ALU_ADD: begin
        res   = sum[W-1:0];
        carry = sum[W];
        ovf   = (a[W-1] == b[W-1]) &&
                (res[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        res   = diff[W-1:0];
        carry = ~diff[W];
        ovf   = (a[W-1] != b[W-1]) &&
                (res[W-1] != a[W-1]);
      end
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_NOTA: res = ~a;
    endcase
  end

endmodule

// File: rtl/datapath_regfile_alu.sv
// 8-entry register file plus ALU; R6/R7 are host-loaded program regs.
// Flags and R0 mirror are registered; bus C is combinational.
module datapath_regfile_alu
  import datapath_regfile_alu_pkg::*;
#(
  parameter int DATAWIDTH     = DEF_DATAWIDTH,
  parameter int SELECTIONALU  = DEF_SELECTIONALU,
  parameter int SELECTIONDECO = DEF_SELECTIONDECO
) (
  input  logic                     clk,
  input  logic                     lowRst,
  input  logic [SELECTIONDECO-1:0] sSelDecoA,
  input  logic [SELECTIONDECO-1:0] sSelDecoB,
  input  logic [SELECTIONDECO-1:0] sSelDecoC,
  input  logic [SELECTIONALU-1:0]  sSelAlu,
  input  logic                     iLoad,
  input  logic [DATAWIDTH-1:0]     iProg0,
  input  logic [DATAWIDTH-1:0]     iProg1,
  output logic                     sOverflow,
  output logic                     sCarry,
  output logic                     sNegative,
  output logic                     sZero,
  output logic [DATAWIDTH-1:0]     oBusC,
  output logic [DATAWIDTH-1:0]     oR0
);

  localparam int NREG = 2 ** SELECTIONDECO;

  logic [DATAWIDTH-1:0] regs [NREG];
  logic [DATAWIDTH-1:0] busA;
  logic [DATAWIDTH-1:0] busB;
  logic                 aluCarry;
  logic                 aluOvf;
  logic                 wrEn;
  logic                 wrBlock;
  flags_t               flags;

  assign busA = regs[sSelDecoA];
  assign busB = regs[sSelDecoB];

  alu_unit #(
    .W   (DATAWIDTH),
    .OPW (SELECTIONALU)
  ) u_alu (
    .op    (sSelAlu),
    .a     (busA),
    .b     (busB),
    .res   (oBusC),
    .carry (aluCarry),
    .ovf   (aluOvf)
  );

  assign wrEn    = (sSelDecoC != SEL_NONE);
  // Host load owns R6 when both target it on the same edge
  assign wrBlock = iLoad && (sSelDecoC == REG_RP0);

  always_ff @(posedge clk) begin
    if (!lowRst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      regs[REG_RP0] <= iProg0;
      regs[REG_RP1] <= iProg1;
      flags         <= '0;
      oR0           <= '0;
    end else begin
      oR0 <= regs[0];
      if (wrEn && !wrBlock) begin
        regs[sSelDecoC] <= oBusC;
      end
      if (iLoad) begin
        regs[REG_RP0] <= iProg0;
        regs[REG_RP1] <= iProg1;
      end
      if (wrEn) begin
        flags.v <= aluOvf;
        flags.c <= aluCarry;
        flags.n <= oBusC[DATAWIDTH-1];
        flags.z <= (oBusC == '0);
      end
    end
  end

  assign sOverflow = flags.v;
  assign sCarry    = flags.c;
  assign sNegative = flags.n;
  assign sZero     = flags.z;

endmodule
